out_display: RTL and testbench

Downstream consumer of the SAP output register: converts the 8-bit unsigned `out` value to three BCD digits with a sequential double-dabble engine and drives a time-multiplexed, 3-digit, common-anode 7-segment display. It sits at the top level between the output register and the board display pins. The bus and CPU are untouched.

---
 rtl/out_display.sv | 184 ++++++++++++++++++
 tb/tb_out_display.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/out_display.sv
// out_display
//   Converts the unsigned byte from the SAP output register to three BCD
//   digits with a sequential double-dabble engine. It then drives a
//   time-multiplexed, 3-digit, common-anode 7-segment display.
//
// Ports
//   clk    in   system clock (unbuffered, keeps running after HLT)
//   clr    in   synchronous active-high reset
//   value  in   [7:0] byte to display
//   seg    out  [6:0] segment cathodes, active-low, seg[0]=a .. seg[6]=g
//   an     out  [2:0] digit anodes, active-low one-hot, an[0]=ones
//   busy   out  high while a conversion is in progress
//
// Parameters
//   SCAN_DIV  clock cycles per digit dwell (2 or more)
//
// The FSM state is held in r_state, typed as state_t. It is easy to probe
// hierarchically.
module out_display #(
  parameter int SCAN_DIV = 1024
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [7:0] value,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       busy
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);
  localparam logic [6:0] BLANK = 7'b1111111;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_LOAD} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [7:0]    r_last;
  logic [19:0]   r_sh;
  logic [2:0]    r_cnt;
  logic [3:0]    r_d2, r_d1, r_d0;
  logic [PW-1:0] r_pre;
  logic [1:0]    r_sel;
  logic [6:0]    r_seg;
  logic [2:0]    r_an;

  logic [19:0]   w_adj;
  logic [19:0]   w_sh_next;
  logic          w_pre_wrap;
  logic [2:0]    w_an_nxt;
  logic [6:0]    w_seg_nxt;
  logic [3:0]    w_digit;
  logic          w_blank;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (clr) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // ---------------- FSM: next-state ----------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (value != r_last) w_next = S_CONV;
      S_CONV:  if (r_cnt == 3'd7)   w_next = S_LOAD;
      S_LOAD:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = (r_state != S_IDLE);
  end

  // One double-dabble step. Every BCD nibble that is 5 or more gets +3,
  // then the whole register shifts left. With an 8-bit input the result
  // stays at 255 or below, so the +3 never carries out of a nibble.
  always_comb begin
    w_adj = r_sh;
    for (int i = 0; i < 3; i++) begin
      if (r_sh[8+4*i +: 4] >= 4'd5)
        w_adj[8+4*i +: 4] = r_sh[8+4*i +: 4] + 4'd3;
    end
    w_sh_next = w_adj << 1;
  end

  // ---------------- conversion datapath ----------------
  always_ff @(posedge clk) begin
    if (clr) begin
      r_last <= 8'd0;
      r_sh   <= 20'd0;
      r_cnt  <= 3'd0;
      r_d2   <= 4'd0;
      r_d1   <= 4'd0;
      r_d0   <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (value != r_last) begin
            r_last <= value;
            r_sh   <= {12'd0, value};
            r_cnt  <= 3'd0;
          end
        end
        S_CONV: begin
          r_sh  <= w_sh_next;
          r_cnt <= r_cnt + 3'd1;
        end
        S_LOAD: begin
          r_d2 <= r_sh[19:16];
          r_d1 <= r_sh[15:12];
          r_d0 <= r_sh[11:8];
        end
        default: ;
      endcase
    end
  end

  // ---------------- scan prescaler and digit select ----------------
  assign w_pre_wrap = (r_pre == PRE_MAX);

  always_ff @(posedge clk) begin
    if (clr) begin
      r_pre <= '0;
      r_sel <= 2'd0;
    end else begin
      r_pre <= w_pre_wrap ? '0 : r_pre + 1'b1;
      // sel==3 is unreachable, but it recovers to 0 if it ever happens.
      if (r_sel == 2'd3)
        r_sel <= 2'd0;
      else if (w_pre_wrap)
        r_sel <= (r_sel == 2'd2) ? 2'd0 : r_sel + 2'd1;
    end
  end

  // The anode and segment pattern for the selected digit are computed here.
  // Both are registered together, so a digit never sees its neighbour's
  // segments.
  always_comb begin
    w_an_nxt  = 3'b111;
    w_digit   = 4'd0;
    w_blank   = 1'b1;
    w_seg_nxt = BLANK;
    case (r_sel)
      2'd0: begin w_an_nxt = 3'b110; w_digit = r_d0; w_blank = 1'b0; end
      2'd1: begin w_an_nxt = 3'b101; w_digit = r_d1;
                  w_blank = (r_d2 == 4'd0) && (r_d1 == 4'd0); end
      2'd2: begin w_an_nxt = 3'b011; w_digit = r_d2;
                  w_blank = (r_d2 == 4'd0); end
      default: ;
    endcase
    if (!w_blank) begin
      case (w_digit)
        4'd0: w_seg_nxt = 7'b1000000;
        4'd1: w_seg_nxt = 7'b1111001;
        4'd2: w_seg_nxt = 7'b0100100;
        4'd3: w_seg_nxt = 7'b0110000;
        4'd4: w_seg_nxt = 7'b0011001;
        4'd5: w_seg_nxt = 7'b0010010;
        4'd6: w_seg_nxt = 7'b0000010;
        4'd7: w_seg_nxt = 7'b1111000;
        4'd8: w_seg_nxt = 7'b0000000;
        4'd9: w_seg_nxt = 7'b0010000;
        default: w_seg_nxt = BLANK;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_an  <= 3'b110;
      r_seg <= 7'b1000000;
    end else begin
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
    end
  end

  assign seg = r_seg;
  assign an  = r_an;

endmodule

// File: tb/tb_out_display.sv
// tb_out_display
//   Self-checking bench for out_display with SCAN_DIV=4. Expected display
//   contents are {hundreds, tens, ones} segment patterns (21 bits). They are
//   pushed to exp_q when a value is driven, and popped when the scanned
//   display has been read back.
module tb_out_display;

  localparam int SD = 4;

  localparam logic [6:0] P0 = 7'b1000000, P1 = 7'b1111001, P2 = 7'b0100100,
                         P3 = 7'b0110000, P4 = 7'b0011001, P5 = 7'b0010010,
                         P6 = 7'b0000010, P7 = 7'b1111000, P8 = 7'b0000000,
                         P9 = 7'b0010000, BL = 7'b1111111;

  logic       clk = 1'b0;
  logic       clr;
  logic [7:0] value;
  logic [6:0] seg;
  logic [2:0] an;
  logic       busy;

  out_display #(.SCAN_DIV(SD)) dut (
    .clk   (clk),
    .clr   (clr),
    .value (value),
    .seg   (seg),
    .an    (an),
    .busy  (busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [20:0] exp_q[$];

  typedef struct {
    logic [7:0]  v;
    logic [20:0] exp;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: pat = P0; 1: pat = P1; 2: pat = P2; 3: pat = P3; 4: pat = P4;
      5: pat = P5; 6: pat = P6; 7: pat = P7; 8: pat = P8; 9: pat = P9;
      default: pat = BL;
    endcase
  endfunction

  // Decimal reference model with leading-zero blanking.
  function automatic logic [20:0] model(input logic [7:0] v);
    int h, t, o;
    logic [6:0] hs, ts;
    h = int'(v) / 100;
    t = (int'(v) / 10) % 10;
    o = int'(v) % 10;
    hs = (h == 0) ? BL : pat(h);
    ts = (h == 0 && t == 0) ? BL : pat(t);
    model = {hs, ts, pat(o)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [7:0] v);
    @(negedge clk);
    value = v;
  endtask

  // Wait until busy is low after at least one edge, with a bounded wait.
  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (busy && n < 40);
    if (busy) check("busy_timeout", 32'(busy), 32'd0);
  endtask

  // Collect the segment pattern for each anode over one scan period.
  task automatic read_display(output logic [20:0] got);
    logic [2:0] seen;
    seen = 3'b000;
    got  = '0;
    @(posedge clk);
    for (int i = 0; i < 3 * SD + 4 && seen != 3'b111; i++) begin
      @(posedge clk); #1;
      case (an)
        3'b110: begin got[6:0]   = seg; seen[0] = 1'b1; end
        3'b101: begin got[13:7]  = seg; seen[1] = 1'b1; end
        3'b011: begin got[20:14] = seg; seen[2] = 1'b1; end
        default: ;
      endcase
    end
    if (seen != 3'b111) check("scan_incomplete", 32'(seen), 32'd7);
  endtask

  task automatic compare_display(input string name);
    logic [20:0] got, exp;
    read_display(got);
    if (exp_q.size() == 0) begin
      check({name, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      exp = exp_q.pop_front();
      check(name, 32'(got), 32'(exp));
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    int n;
    logic [2:0] prev_an;
    logic       found;
    logic       busy_seen;
    logic [2:0] exp_an;
    logic [6:0] exp_seg;

    tbl[0] = '{8'd7,   {BL, BL, P7}};
    tbl[1] = '{8'd105, {P1, P0, P5}};
    tbl[2] = '{8'd10,  {BL, P1, P0}};
    tbl[3] = '{8'd0,   {BL, BL, P0}};
    tbl[4] = '{8'd100, {P1, P0, P0}};
    tbl[5] = '{8'd128, {P1, P2, P8}};
    tbl[6] = '{8'd64,  {BL, P6, P4}};
    tbl[7] = '{8'd239, {P2, P3, P9}};

    // Reset: two cycles with clr high.
    clr   = 1'b1;
    value = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_an",   32'(an),   32'b110);
    check("reset_seg",  32'(seg),  32'b1000000);
    check("reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    clr = 1'b0;
    busy_seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (busy) busy_seen = 1'b1;
    end
    check("zero_no_conv", 32'(busy_seen), 32'd0);

    // Full scale: the busy window and the scan sequence.
    @(negedge clk);
    value = 8'd255;
    exp_q.push_back(model(8'd255));
    @(posedge clk); #1;
    check("busy_rise", 32'(busy), 32'd1);
    n = 1;
    while (busy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    // The edges from acceptance up to the edge that returns to IDLE are
    // counted inclusively: 1 accept, 8 shifts, 1 load.
    check("busy_window", 32'(n), 32'd10);
    compare_display("disp_255");

    prev_an = an;
    found   = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      if (an == 3'b110 && prev_an != 3'b110) found = 1'b1;
      else prev_an = an;
    end
    check("scan_sync", 32'(found), 32'd1);
    for (int i = 0; i < 3 * SD; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      exp_an  = (i < SD) ? 3'b110 : (i < 2 * SD) ? 3'b101 : 3'b011;
      exp_seg = (i < 2 * SD) ? P5 : P2;
      check($sformatf("scan_an_%0d", i),  32'(an),  32'(exp_an));
      check($sformatf("scan_seg_%0d", i), 32'(seg), 32'(exp_seg));
    end

    // Table-driven vectors.
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].v);
      exp_q.push_back(tbl[i].exp);
      wait_idle();
      compare_display($sformatf("tbl_%0d", tbl[i].v));
    end

    // Mid-conversion change: 200, then 37 three cycles into CONV.
    @(negedge clk);
    value = 8'd200;
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    value = 8'd37;
    exp_q.push_back(model(8'd37));
    n = 4;
    #1;
    while (busy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("mid_first_done", 32'(n), 32'd10);
    check("mid_first_digits", 32'({dut.r_d2, dut.r_d1, dut.r_d0}), 32'h200);
    @(posedge clk); #1;
    check("mid_reconvert", 32'(busy), 32'd1);
    wait_idle();
    compare_display("mid_final_37");

    // Reset while cnt==4 with value 99.
    @(negedge clk);
    value = 8'd99;
    @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy",   32'(busy), 32'd0);
    check("midrst_digits", 32'({dut.r_d2, dut.r_d1, dut.r_d0}), 32'h000);
    check("midrst_an",     32'(an),   32'b110);
    check("midrst_seg",    32'(seg),  32'b1000000);
    @(negedge clk);
    clr = 1'b0;
    exp_q.push_back(model(8'd99));
    wait_idle();
    compare_display("midrst_99");

    // Exhaustive sweep.
    for (int v = 0; v < 256; v++) begin
      drive(8'(v));
      exp_q.push_back(model(8'(v)));
      wait_idle();
      compare_display($sformatf("sweep_%0d", v));
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
